// File: rtl/mem1b_arbiter_if.sv
// Bundle of the two client request channels plus the memory-side
// signals of mem1b_arbiter.
//   slave  : the arbiter's view (requests and mem_dout in, grants and memory controls out)
//   master : the clients-plus-memory view (the opposite directions)
interface mem1b_arbiter_if;
    // Client 0 channel
    logic req0;
    logic we0;
    logic addr0;
    logic wdata0;
    logic gnt0;
    logic done0;
    // Client 1 channel
    logic req1;
    logic we1;
    logic addr1;
    logic wdata1;
    logic gnt1;
    logic done1;
    // Shared results
    logic rdata;
    logic err;
    // Memory side
    logic mem_we;
    logic mem_addr;
    logic mem_din;
    logic mem_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output gnt0, done0, gnt1, done1,
        output rdata, err,
        output mem_we, mem_addr, mem_din
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  gnt0, done0, gnt1, done1,
        input  rdata, err,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem1b_arbiter.sv
// Round-robin arbiter that shares one external 2x1-bit memory between two
// clients. Every access runs IDLE -> SETTLE -> ACCESS -> DONE so the slow
// valve logic behind the memory settles before write_enable fires or before
// read data is captured.
// Optional feature: define MEM1B_ARB_WRITE_VERIFY_EN to add a read-back check
// after every write (VERIFY_SETTLE -> VERIFY). A mismatch raises err during DONE.
module mem1b_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input logic           clk,
    input logic           rst,
    mem1b_arbiter_if.slave bus
);

    // The settle counter must reach SETTLE_CYCLES-1 without wrapping.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_settle
            $error("mem1b_arbiter: SETTLE_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCESS,
        DONE
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
        , VERIFY_SETTLE,
        VERIFY
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             last_q,  last_d;   // client granted most recently
    logic             owner_q, owner_d;  // client owning the current access
    logic             we_q,    we_d;
    logic             addr_q,  addr_d;
    logic             din_q,   din_d;
    logic             rdata_q, rdata_d;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
    logic             fail_q,  fail_d;
`endif

    // Next-state, arbitration and datapath update for the access sequence
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            IDLE: begin
                // Client 0 wins when alone or when client 1 was served last.
                if (bus.req0 && (!bus.req1 || last_q)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    we_d    = bus.we0;
                    addr_d  = bus.addr0;
                    din_d   = bus.wdata0;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
                    fail_d  = 1'b0;
`endif
                end else if (bus.req1) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    we_d    = bus.we1;
                    addr_d  = bus.addr1;
                    din_d   = bus.wdata1;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
                    fail_d  = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = bus.mem_dout;
                end
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
                state_d = we_q ? VERIFY_SETTLE : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
            VERIFY_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = VERIFY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            VERIFY: begin
                fail_d  = (bus.mem_dout != din_q);
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 1'b0;
            din_q   <= 1'b0;
            rdata_q <= 1'b0;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
            fail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
            fail_q  <= fail_d;
`endif
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    assign bus.gnt0     = (state_q != IDLE) && !owner_q;
    assign bus.gnt1     = (state_q != IDLE) &&  owner_q;
    assign bus.done0    = (state_q == DONE) && !owner_q;
    assign bus.done1    = (state_q == DONE) &&  owner_q;
    assign bus.mem_we   = (state_q == ACCESS) && we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.rdata    = rdata_q;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
    assign bus.err      = (state_q == DONE) && fail_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem1b_arbiter.sv
// Scoreboard bench for mem1b_arbiter: the stimulus side predicts each
// transaction (service order, completion cycle, read data, err) from a
// transaction-level model and queues it; a monitor checks memory strobes and
// done pulses against the queue head.
module tb_mem1b_arbiter;

    localparam int S = 2;
`ifdef MEM1B_ARB_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct {
        bit client;
        bit we;
        bit addr;
        bit wdata;
        bit rdata;
        bit err;
        int done_cyc;
        int access_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_q = 1'b1;

    int vectors    = 0;
    int miscompares = 0;

    mem1b_arbiter_if bus ();

    mem1b_arbiter #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // External memory: no reset, asynchronous read, optional stuck-at-0 read path.
    bit tb_mem [2] = '{1'b0, 1'b0};
    bit force_zero = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_din;
    end
    assign bus.mem_dout = force_zero ? 1'b0 : tb_mem[bus.mem_addr];

    // Reference model state
    bit   ref_mem [2] = '{1'b0, 1'b0};
    bit   ref_last    = 1'b1;
    txn_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d: event seen, none expected", name, cyc);
    endtask

    // Predict one transaction served right after the completion at prev_done.
    task automatic predict(input bit c, input bit we, input bit a, input bit d, inout int prev_done);
        txn_t t;
        int   lat;
        bit   wr_chk;
        wr_chk       = VERIFY && we;
        lat          = wr_chk ? 2 * S + 3 : S + 2;
        t.client     = c;
        t.we         = we;
        t.addr       = a;
        t.wdata      = d;
        t.rdata      = ref_mem[a];
        t.err        = wr_chk && ((force_zero ? 1'b0 : d) != d);
        t.done_cyc   = prev_done + 1 + lat;
        t.access_cyc = t.done_cyc - (wr_chk ? S + 2 : 1);
        if (we) ref_mem[a] = d;
        ref_last     = c;
        prev_done    = t.done_cyc;
        exp_q.push_back(t);
    endtask

    // Raise the selected requests together, then act as both clients until served.
    task automatic run_batch(input bit r0, input bit r1,
                             input bit w0, input bit a0, input bit d0,
                             input bit w1, input bit a1, input bit d1);
        int  prev_done;
        bit  first;
        bit  served;
        if (!r0 && !r1) return;
        @(negedge clk);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        prev_done = cyc - 1;
        first = (r0 && r1) ? ~ref_last : r1;
        if (first) predict(1'b1, w1, a1, d1, prev_done);
        else       predict(1'b0, w0, a0, d0, prev_done);
        if (r0 && r1) begin
            if (first) predict(1'b0, w0, a0, d0, prev_done);
            else       predict(1'b1, w1, a1, d1, prev_done);
        end
        served = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            // Inputs of an already-granted client are scrambled: they must be ignored.
            if (bus.req0 && bus.done0 === 1'b1) bus.req0 = 1'b0;
            else if (bus.req0 && bus.gnt0 === 1'b1) begin
                bus.we0 = 1'($urandom); bus.addr0 = 1'($urandom); bus.wdata0 = 1'($urandom);
            end
            if (bus.req1 && bus.done1 === 1'b1) bus.req1 = 1'b0;
            else if (bus.req1 && bus.gnt1 === 1'b1) begin
                bus.we1 = 1'($urandom); bus.addr1 = 1'($urandom); bus.wdata1 = 1'($urandom);
            end
            if (!bus.req0 && !bus.req1) begin
                served = 1'b1;
                break;
            end
        end
        if (!served) begin
            fail_evt("batch_timeout");
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            exp_q.delete();
        end
    endtask

    // Monitor: memory strobes and done pulses against the head of the scoreboard.
    txn_t mon_t;
    bit   rdata_hold = 1'b0;
    always @(negedge clk) begin
        if (rst_q) begin
            rdata_hold = 1'b0;
        end else begin
            if (bus.mem_we === 1'b1) begin
                if (exp_q.size() == 0) fail_evt("unexpected_mem_we");
                else begin
                    check("mem_we_cycle", cyc, exp_q[0].access_cyc);
                    check("mem_we_on_write", 32'(exp_q[0].we), 32'd1);
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                    check("mem_din", 32'(bus.mem_din), 32'(exp_q[0].wdata));
                end
            end
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
                if (exp_q.size() == 0) fail_evt("unexpected_done");
                else begin
                    mon_t = exp_q.pop_front();
                    check("done_client", 32'({bus.done1, bus.done0}), mon_t.client ? 32'd2 : 32'd1);
                    check("gnt_at_done", 32'({bus.gnt1, bus.gnt0}), mon_t.client ? 32'd2 : 32'd1);
                    check("done_cycle", cyc, mon_t.done_cyc);
                    check("err", 32'(bus.err), 32'(mon_t.err));
                    if (!mon_t.we) begin
                        check("rdata", 32'(bus.rdata), 32'(mon_t.rdata));
                        rdata_hold = mon_t.rdata;
                    end else begin
                        check("rdata_hold", 32'(bus.rdata), 32'(rdata_hold));
                    end
                end
            end
        end
    end

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 1'b0; bus.wdata0 = 1'b0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 1'b0; bus.wdata1 = 1'b0;

        // Reset for two cycles: every output low.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_we,
                   bus.mem_addr, bus.mem_din, bus.rdata, bus.err}), 32'd0);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({bus.gnt0, bus.gnt1, bus.mem_we, bus.done0, bus.done1}), 32'd0);
        end

        // Contention straight out of reset: client 0 first.
        run_batch(1, 1, 1, 0, 0, 0, 1, 0);
        // Single write, then read-back by the other client.
        run_batch(1, 0, 1, 1, 1, 0, 0, 0);
        run_batch(0, 1, 0, 0, 0, 0, 1, 0);
        run_batch(1, 0, 1, 0, 0, 0, 0, 0);
        run_batch(0, 1, 0, 0, 0, 0, 0, 0);
        // Repeated contention alternates according to round-robin history.
        run_batch(1, 1, 0, 1, 0, 0, 0, 0);
        run_batch(1, 1, 0, 0, 0, 0, 1, 0);

        // Reset during SETTLE: grant drops, no strobe, no done.
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 1'b0; bus.wdata0 = 1'b1;
        @(negedge clk);
        check("midop_granted", 32'(bus.gnt0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midop_after_reset",
              32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_we}), 32'd0);
        rst = 1'b0;
        bus.req0 = 1'b0;
        ref_last = 1'b1;
        repeat (5) @(negedge clk);
        run_batch(1, 0, 0, 0, 0, 0, 0, 0);
        run_batch(0, 1, 1, 0, 0, 1, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            run_batch(r0, r1,
                      1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef MEM1B_ARB_WRITE_VERIFY_EN
        // Read path stuck at 0: writing a 1 must flag err; normal path must not.
        force_zero = 1'b1;
        run_batch(1, 0, 1, 1, 1, 0, 0, 0);
        force_zero = 1'b0;
        run_batch(1, 0, 1, 1, 1, 0, 0, 0);
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail_evt("missing_done");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
